// File: rtl/stage_wb_pkg.sv
// ---------------------------------------------------------------------------
// stage_wb_pkg
// Shared definitions for the writeback stage:
//   - wb_state_e      : FSM state encoding (IDLE=0, WAIT_ACK=1)
//   - cause constants : RISC-V load/store exception cause codes
//   - fault_cause()   : picks the access-fault cause for a load or a store
// ---------------------------------------------------------------------------
package stage_wb_pkg;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } wb_state_e;

   localparam logic [3:0] LD_MISALIGN = 4'd4;
   localparam logic [3:0] LD_FAULT    = 4'd5;
   localparam logic [3:0] ST_MISALIGN = 4'd6;
   localparam logic [3:0] ST_FAULT    = 4'd7;

   function automatic logic [3:0] fault_cause(input logic is_ld);
      return is_ld ? LD_FAULT : ST_FAULT;
   endfunction

endpackage

// File: rtl/wb_bus_timer.sv
// ---------------------------------------------------------------------------
// wb_bus_timer
// 8-bit cycle counter that measures how long a bus access has been pending.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr           : restart the count at zero (wins over en)
//   en            : count one cycle
//   timeout       : high while enabled and the count equals BUS_TIMEOUT-1
// ---------------------------------------------------------------------------
module wb_bus_timer #(
   parameter int unsigned BUS_TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr,
   input  logic en,
   output logic timeout
);

   localparam logic [7:0] LAST = 8'(BUS_TIMEOUT - 1);

   logic [7:0] cnt;

   // Cycle counter: cleared on entry to a bus wait, advanced while waiting.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt <= 8'd0;
      end else if (clr) begin
         cnt <= 8'd0;
      end else if (en) begin
         cnt <= cnt + 8'd1;
      end else begin
         cnt <= cnt;
      end
   end

   // Gated with en so a stale count never fires outside a wait.
   assign timeout = en & (cnt == LAST);

endmodule

// File: rtl/stage_wb.sv
// ---------------------------------------------------------------------------
// stage_wb
// Writeback stage: completes each instruction leaving the memory stage,
// waits for the Wishbone termination of loads/stores, writes the register
// file, reports load/store exceptions and counts retired instructions.
// Ports:
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   valid_i, flush_i               : incoming instruction / discard request
//   pc_i, rd_addr_i, rd_we_i       : instruction PC, destination, write enable
//   is_ld_i, is_st_i               : memory op type
//   alu_result_i, ld_data_i        : ALU result (= address), formatted load data
//   e_ld_addr_mis_i, e_st_addr_mis_i : misalignment flags
//   wbm_ack_i, wbm_err_i           : bus termination
//   stall_o                        : hold upstream (combinational)
//   rf_we_o/rf_waddr_o/rf_wdata_o  : register-file write (registered)
//   fwd_valid_o/fwd_addr_o/fwd_data_o : copy of the rf write for bypass
//   exc_valid_o/exc_cause_o/exc_pc_o/exc_tval_o : exception report
//   retire_o, instret_o            : retire pulse, 64-bit retired count
// ---------------------------------------------------------------------------
module stage_wb
   import stage_wb_pkg::*;
#(
   parameter int unsigned BUS_TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        valid_i,
   input  logic        flush_i,
   input  logic [31:0] pc_i,
   input  logic [4:0]  rd_addr_i,
   input  logic        rd_we_i,
   input  logic        is_ld_i,
   input  logic        is_st_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] ld_data_i,
   input  logic        e_ld_addr_mis_i,
   input  logic        e_st_addr_mis_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   output logic        stall_o,
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   output logic        fwd_valid_o,
   output logic [4:0]  fwd_addr_o,
   output logic [31:0] fwd_data_o,
   output logic        exc_valid_o,
   output logic [3:0]  exc_cause_o,
   output logic [31:0] exc_pc_o,
   output logic [31:0] exc_tval_o,
   output logic        retire_o,
   output logic [63:0] instret_o
);

   wb_state_e   state;
   logic [31:0] lat_pc;
   logic [4:0]  lat_rd;
   logic        lat_is_ld;
   logic [31:0] lat_addr;
   logic        flushed;

   logic        mem_op;
   logic        misaligned;
   logic        bus_term;
   logic        accept;
   logic        in_wait;
   logic        drop;
   logic        timeout;

   logic        do_wr;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        do_exc;
   logic [3:0]  exc_cause;
   logic [31:0] exc_pc;
   logic [31:0] exc_tval;
   logic        do_ret;
   logic        go_wait;
   logic        go_idle;

   assign mem_op     = is_ld_i | is_st_i;
   assign misaligned = (is_ld_i & e_ld_addr_mis_i) | (is_st_i & e_st_addr_mis_i);
   assign bus_term   = wbm_ack_i | wbm_err_i;
   assign accept     = (state == IDLE) & valid_i & ~flush_i;
   assign in_wait    = (state == WAIT_ACK);
   // A flush in the terminating cycle itself also cancels the result.
   assign drop       = flushed | flush_i;

   assign stall_o = (accept & mem_op & ~misaligned & ~bus_term)
                  | (in_wait & ~bus_term & ~timeout);

   wb_bus_timer #(
      .BUS_TIMEOUT (BUS_TIMEOUT)
   ) u_timer (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr     (go_wait),
      .en      (in_wait),
      .timeout (timeout)
   );

   // Completion decision for this cycle: what to write, report and retire.
   always_comb begin
      do_wr     = 1'b0;
      wr_addr   = rd_addr_i;
      wr_data   = alu_result_i;
      do_exc    = 1'b0;
      exc_cause = LD_MISALIGN;
      exc_pc    = pc_i;
      exc_tval  = alu_result_i;
      do_ret    = 1'b0;
      go_wait   = 1'b0;
      go_idle   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (misaligned) begin
                  do_exc    = 1'b1;
                  exc_cause = is_ld_i ? LD_MISALIGN : ST_MISALIGN;
               end else if (mem_op && wbm_err_i) begin
                  do_exc    = 1'b1;
                  exc_cause = fault_cause(is_ld_i);
               end else if (mem_op && wbm_ack_i) begin
                  do_ret  = 1'b1;
                  do_wr   = is_ld_i & (rd_addr_i != 5'd0);
                  wr_data = ld_data_i;
               end else if (mem_op) begin
                  go_wait = 1'b1;
               end else begin
                  do_ret = 1'b1;
                  do_wr  = rd_we_i & (rd_addr_i != 5'd0);
               end
            end else begin
               go_wait = 1'b0;
            end
         end
         WAIT_ACK: begin
            wr_addr   = lat_rd;
            wr_data   = ld_data_i;
            exc_cause = fault_cause(lat_is_ld);
            exc_pc    = lat_pc;
            exc_tval  = lat_addr;
            // err beats ack; the timeout only counts when neither arrived.
            if (wbm_err_i) begin
               go_idle = 1'b1;
               do_exc  = ~drop;
            end else if (wbm_ack_i) begin
               go_idle = 1'b1;
               do_ret  = ~drop;
               do_wr   = ~drop & lat_is_ld & (lat_rd != 5'd0);
            end else if (timeout) begin
               go_idle = 1'b1;
               do_exc  = ~drop;
            end else begin
               go_idle = 1'b0;
            end
         end
         default: begin
            go_idle = 1'b1;
         end
      endcase
   end

   // FSM, latched access context and all registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         lat_pc      <= 32'd0;
         lat_rd      <= 5'd0;
         lat_is_ld   <= 1'b0;
         lat_addr    <= 32'd0;
         flushed     <= 1'b0;
         rf_we_o     <= 1'b0;
         rf_waddr_o  <= 5'd0;
         rf_wdata_o  <= 32'd0;
         exc_valid_o <= 1'b0;
         exc_cause_o <= 4'd0;
         exc_pc_o    <= 32'd0;
         exc_tval_o  <= 32'd0;
         retire_o    <= 1'b0;
         instret_o   <= 64'd0;
      end else begin
         if (go_wait) begin
            state     <= WAIT_ACK;
            lat_pc    <= pc_i;
            lat_rd    <= rd_addr_i;
            lat_is_ld <= is_ld_i;
            lat_addr  <= alu_result_i;
            flushed   <= 1'b0;
         end else if (go_idle) begin
            state   <= IDLE;
            flushed <= 1'b0;
         end else if (in_wait && flush_i) begin
            flushed <= 1'b1;
         end else begin
            flushed <= flushed;
         end

         rf_we_o <= do_wr;
         if (do_wr) begin
            rf_waddr_o <= wr_addr;
            rf_wdata_o <= wr_data;
         end

         exc_valid_o <= do_exc;
         if (do_exc) begin
            exc_cause_o <= exc_cause;
            exc_pc_o    <= exc_pc;
            exc_tval_o  <= exc_tval;
         end

         retire_o <= do_ret;
         if (do_ret) begin
            instret_o <= instret_o + 64'd1;
         end
      end
   end

   assign fwd_valid_o = rf_we_o;
   assign fwd_addr_o  = rf_waddr_o;
   assign fwd_data_o  = rf_wdata_o;

endmodule

// File: tb/tb_stage_wb.sv
// ---------------------------------------------------------------------------
// tb_stage_wb
// Self-checking bench for stage_wb: a directed vector table of single-cycle
// completions, hand-written multi-cycle sequences (delayed ack, timeout,
// flush during a wait, reset during a wait) and a randomized instruction
// stream checked against a per-instruction outcome model.
// ---------------------------------------------------------------------------
module tb_stage_wb;

   localparam int BT = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        valid_i, flush_i, rd_we_i, is_ld_i, is_st_i;
   logic [31:0] pc_i, alu_result_i, ld_data_i;
   logic [4:0]  rd_addr_i;
   logic        e_ld_addr_mis_i, e_st_addr_mis_i, wbm_ack_i, wbm_err_i;
   logic        stall_o, rf_we_o, fwd_valid_o, exc_valid_o, retire_o;
   logic [4:0]  rf_waddr_o, fwd_addr_o;
   logic [31:0] rf_wdata_o, fwd_data_o, exc_pc_o, exc_tval_o;
   logic [3:0]  exc_cause_o;
   logic [63:0] instret_o;

   int n_chk = 0;
   int n_err = 0;

   // model of the held output values
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata, m_epc, m_tval;
   logic [3:0]  m_cause;
   logic [63:0] m_instret;

   typedef struct {
      logic valid, flush, ld, st, mis, ack, err, rwe;
      logic [4:0]  rd;
      logic [31:0] pc, alu, ldd;
      logic ewe;
      logic [4:0]  ea;
      logic [31:0] ed;
      logic eexc;
      logic [3:0]  ec;
      logic eret;
   } vec_t;

   vec_t vt[13];

   stage_wb #(.BUS_TIMEOUT(BT)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .flush_i(flush_i),
      .pc_i(pc_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
      .is_ld_i(is_ld_i), .is_st_i(is_st_i), .alu_result_i(alu_result_i),
      .ld_data_i(ld_data_i), .e_ld_addr_mis_i(e_ld_addr_mis_i),
      .e_st_addr_mis_i(e_st_addr_mis_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
      .stall_o(stall_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
      .rf_wdata_o(rf_wdata_o), .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o),
      .fwd_data_o(fwd_data_o), .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o),
      .exc_pc_o(exc_pc_o), .exc_tval_o(exc_tval_o), .retire_o(retire_o),
      .instret_o(instret_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic valid, flush, ld, st, mis, ack, err, rwe,
                               input logic [4:0] rd, input logic [31:0] pc, alu, ldd,
                               input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                               input logic eexc, input logic [3:0] ec, input logic eret);
      vec_t v;
      v.valid = valid; v.flush = flush; v.ld = ld; v.st = st; v.mis = mis;
      v.ack = ack; v.err = err; v.rwe = rwe; v.rd = rd; v.pc = pc; v.alu = alu;
      v.ldd = ldd; v.ewe = ewe; v.ea = ea; v.ed = ed; v.eexc = eexc; v.ec = ec;
      v.eret = eret;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Update the held-value model with this cycle's expected events, then compare.
   task automatic check_out(input string tag, input logic ewe, input logic [4:0] ea,
                            input logic [31:0] ed, input logic eexc, input logic [3:0] ec,
                            input logic [31:0] epc, input logic [31:0] etv, input logic eret);
      if (ewe) begin
         m_waddr = ea;
         m_wdata = ed;
      end
      if (eexc) begin
         m_cause = ec;
         m_epc   = epc;
         m_tval  = etv;
      end
      if (eret) m_instret = m_instret + 64'd1;
      chk($sformatf("%s.rf_we", tag),     64'(rf_we_o),     64'(ewe));
      chk($sformatf("%s.rf_waddr", tag),  64'(rf_waddr_o),  64'(m_waddr));
      chk($sformatf("%s.rf_wdata", tag),  64'(rf_wdata_o),  64'(m_wdata));
      chk($sformatf("%s.fwd_valid", tag), 64'(fwd_valid_o), 64'(ewe));
      chk($sformatf("%s.fwd_addr", tag),  64'(fwd_addr_o),  64'(m_waddr));
      chk($sformatf("%s.fwd_data", tag),  64'(fwd_data_o),  64'(m_wdata));
      chk($sformatf("%s.exc_valid", tag), 64'(exc_valid_o), 64'(eexc));
      chk($sformatf("%s.exc_cause", tag), 64'(exc_cause_o), 64'(m_cause));
      chk($sformatf("%s.exc_pc", tag),    64'(exc_pc_o),    64'(m_epc));
      chk($sformatf("%s.exc_tval", tag),  64'(exc_tval_o),  64'(m_tval));
      chk($sformatf("%s.retire", tag),    64'(retire_o),    64'(eret));
      chk($sformatf("%s.instret", tag),   instret_o,        m_instret);
   endtask

   task automatic drive_idle();
      valid_i = 1'b0; flush_i = 1'b0; rd_we_i = 1'b0; is_ld_i = 1'b0; is_st_i = 1'b0;
      pc_i = 32'd0; rd_addr_i = 5'd0; alu_result_i = 32'd0; ld_data_i = 32'd0;
      e_ld_addr_mis_i = 1'b0; e_st_addr_mis_i = 1'b0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
   endtask

   task automatic idle_cycle(input string tag);
      drive_idle();
      #1;
      chk($sformatf("%s.stall", tag), 64'(stall_o), 64'd0);
      @(posedge clk_i); #1;
      check_out(tag, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
   endtask

   // One instruction from accept to completion.
   //   kind : 0 ALU, 1 load, 2 store
   //   d    : cycles after accept at which the bus terminates (0 = same cycle)
   //   term : 0 ack, 1 err, 2 no termination (timeout), 3 ack and err together
   //   flush_at : -1 none, 0 flush in the accept cycle, k>0 flush k cycles later
   task automatic run_instr(input string tag, input int kind, input logic [4:0] rd,
                            input logic rwe, input logic [31:0] pc, input logic [31:0] addr,
                            input logic [31:0] ldd, input logic mis, input int d,
                            input int term, input int flush_at);
      int   dend;
      logic mem, dropped, flushed, fault, ewe, eexc, eret;
      logic [3:0]  ec;
      logic [31:0] ed;
      mem     = (kind != 0);
      dropped = (flush_at == 0);
      dend    = 0;
      if (mem && !mis && !dropped) dend = (term == 2) ? BT : d;
      flushed = (flush_at >= 1) && (flush_at <= dend);
      fault   = mem && !mis && (term != 0);
      for (int k = 0; k <= dend; k++) begin
         valid_i = 1'b1; flush_i = (k == flush_at); pc_i = pc; rd_addr_i = rd;
         rd_we_i = rwe; is_ld_i = (kind == 1); is_st_i = (kind == 2);
         alu_result_i = addr; ld_data_i = ldd;
         e_ld_addr_mis_i = mis && (kind == 1);
         e_st_addr_mis_i = mis && (kind == 2);
         wbm_ack_i = (k == dend) && (dend > 0 || (mem && !mis && !dropped)) &&
                     (term == 0 || term == 3);
         wbm_err_i = (k == dend) && (dend > 0 || (mem && !mis && !dropped)) &&
                     (term == 1 || term == 3);
         #1;
         chk($sformatf("%s.stall[%0d]", tag, k), 64'(stall_o), 64'(k < dend));
         @(posedge clk_i); #1;
         if (k < dend)
            check_out($sformatf("%s.wait[%0d]", tag, k), 1'b0, 5'd0, 32'd0,
                      1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      end
      ewe = 1'b0; eexc = 1'b0; eret = 1'b0; ec = 4'd0; ed = 32'd0;
      if (dropped || flushed) begin
         eret = 1'b0;
      end else if (mem && mis) begin
         eexc = 1'b1;
         ec   = (kind == 1) ? 4'd4 : 4'd6;
      end else if (fault) begin
         eexc = 1'b1;
         ec   = (kind == 1) ? 4'd5 : 4'd7;
      end else begin
         eret = 1'b1;
         ewe  = (rd != 5'd0) && ((kind == 1) || (kind == 0 && rwe));
         ed   = (kind == 1) ? ldd : addr;
      end
      check_out(tag, ewe, rd, ed, eexc, ec, pc, addr, eret);
   endtask

   initial begin
      int          kind, d, term, flush_at, r;
      logic        mis, rwe;
      logic [4:0]  rd;

      m_waddr = 5'd0; m_wdata = 32'd0; m_epc = 32'd0; m_tval = 32'd0;
      m_cause = 4'd0; m_instret = 64'd0;
      drive_idle();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check_out("reset", 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      chk("reset.stall", 64'(stall_o), 64'd0);
      rst_ni = 1'b1;

      // ---------------- directed single-cycle vectors ----------------
      vt[0]  = mk(1,0,0,0,0,0,0,1, 5, 32'h100, 32'h1234, 32'h0,     1, 5, 32'h1234, 0, 4'd0, 1);
      vt[1]  = mk(1,0,0,0,0,0,0,1, 0, 32'h104, 32'h5555, 32'h0,     0, 0, 32'h0,    0, 4'd0, 1);
      vt[2]  = mk(1,0,0,0,0,0,0,0, 3, 32'h108, 32'h7777, 32'h0,     0, 0, 32'h0,    0, 4'd0, 1);
      vt[3]  = mk(1,0,1,0,0,1,0,1, 9, 32'h10C, 32'h4000, 32'hCAFEF00D, 1, 9, 32'hCAFEF00D, 0, 4'd0, 1);
      vt[4]  = mk(1,0,0,1,0,1,0,1, 2, 32'h110, 32'h4004, 32'h0,     0, 0, 32'h0,    0, 4'd0, 1);
      vt[5]  = mk(1,0,1,0,1,0,0,1, 8, 32'h200, 32'h1001, 32'h11,    0, 0, 32'h0,    1, 4'd4, 0);
      vt[6]  = mk(1,0,0,1,1,0,0,0, 0, 32'h204, 32'h2002, 32'h0,     0, 0, 32'h0,    1, 4'd6, 0);
      vt[7]  = mk(1,0,1,0,0,1,1,1,10, 32'h208, 32'h3000, 32'h99,    0, 0, 32'h0,    1, 4'd5, 0);
      vt[8]  = mk(1,0,0,1,0,0,1,0, 0, 32'h20C, 32'h3004, 32'h0,     0, 0, 32'h0,    1, 4'd7, 0);
      vt[9]  = mk(1,0,1,0,0,1,0,1, 0, 32'h210, 32'h50,   32'h1,     0, 0, 32'h0,    0, 4'd0, 1);
      vt[10] = mk(1,1,1,0,0,0,0,1, 6, 32'h214, 32'h60,   32'h2,     0, 0, 32'h0,    0, 4'd0, 0);
      vt[11] = mk(0,0,0,0,0,0,0,1,12, 32'h218, 32'h70,   32'h0,     0, 0, 32'h0,    0, 4'd0, 0);
      vt[12] = mk(1,0,0,0,0,0,0,1,31, 32'h21C, 32'hFFFFFFFF, 32'h0, 1,31, 32'hFFFFFFFF, 0, 4'd0, 1);

      for (int i = 0; i < 13; i++) begin
         valid_i = vt[i].valid; flush_i = vt[i].flush; is_ld_i = vt[i].ld; is_st_i = vt[i].st;
         e_ld_addr_mis_i = vt[i].mis & vt[i].ld; e_st_addr_mis_i = vt[i].mis & vt[i].st;
         wbm_ack_i = vt[i].ack; wbm_err_i = vt[i].err; rd_we_i = vt[i].rwe;
         rd_addr_i = vt[i].rd; pc_i = vt[i].pc; alu_result_i = vt[i].alu; ld_data_i = vt[i].ldd;
         #1;
         chk($sformatf("vec%0d.stall", i), 64'(stall_o), 64'd0);
         @(posedge clk_i); #1;
         check_out($sformatf("vec%0d", i), vt[i].ewe, vt[i].ea, vt[i].ed, vt[i].eexc,
                   vt[i].ec, vt[i].pc, vt[i].alu, vt[i].eret);
      end

      // ---------------- hand-written multi-cycle sequences ----------------
      run_instr("ld_ack3", 1, 5'd7, 1'b1, 32'h300, 32'h800, 32'hDEADBEEF, 1'b0, 3, 0, -1);
      run_instr("alu_b2b0", 0, 5'd1, 1'b1, 32'h304, 32'hA1, 32'h0, 1'b0, 0, 0, -1);
      run_instr("alu_b2b1", 0, 5'd2, 1'b1, 32'h308, 32'hA2, 32'h0, 1'b0, 0, 0, -1);
      run_instr("st_timeout", 2, 5'd0, 1'b0, 32'h30C, 32'h9000, 32'h0, 1'b0, 0, 2, -1);
      run_instr("ld_flush", 1, 5'd4, 1'b1, 32'h310, 32'h804, 32'h12345678, 1'b0, 3, 0, 1);
      run_instr("ld_waiterr", 1, 5'd4, 1'b1, 32'h314, 32'h808, 32'h0, 1'b0, 2, 1, -1);
      idle_cycle("gap");

      // reset in the middle of a pending load
      valid_i = 1'b1; flush_i = 1'b0; is_ld_i = 1'b1; is_st_i = 1'b0; rd_addr_i = 5'd9;
      rd_we_i = 1'b1; pc_i = 32'h400; alu_result_i = 32'h900; ld_data_i = 32'h55;
      e_ld_addr_mis_i = 1'b0; e_st_addr_mis_i = 1'b0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      drive_idle();
      #2;
      rst_ni = 1'b0;
      #1;
      m_waddr = 5'd0; m_wdata = 32'd0; m_epc = 32'd0; m_tval = 32'd0;
      m_cause = 4'd0; m_instret = 64'd0;
      check_out("rst_async", 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      chk("rst_async.stall", 64'(stall_o), 64'd0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      wbm_ack_i = 1'b1;
      ld_data_i = 32'h66;
      #1;
      chk("rst_lateack.stall", 64'(stall_o), 64'd0);
      @(posedge clk_i); #1;
      check_out("rst_lateack", 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
      run_instr("post_rst", 0, 5'd3, 1'b1, 32'h500, 32'hBEEF, 32'h0, 1'b0, 0, 0, -1);

      // ---------------- randomized instruction stream ----------------
      for (int n = 0; n < 300; n++) begin
         kind = int'($urandom_range(0, 2));
         rd   = 5'($urandom_range(0, 31));
         rwe  = 1'($urandom_range(0, 1));
         mis  = (kind != 0) && ($urandom_range(0, 7) == 0);
         d    = int'($urandom_range(0, 4));
         r    = int'($urandom_range(0, 15));
         term = (r <= 10) ? 0 : (r <= 12) ? 1 : (r == 13) ? 3 : 2;
         r    = int'($urandom_range(0, 15));
         flush_at = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(1, 4)) : -1;
         run_instr($sformatf("rnd%0d", n), kind, rd, rwe, $urandom, $urandom, $urandom,
                   mis, d, term, flush_at);
         if ($urandom_range(0, 5) == 0) idle_cycle($sformatf("rnd%0d.gap", n));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
